// File: rtl/fsm_state_tracker_if.sv
// Sample/status bundle between the monitored link and the state tracker.
// The master drives samples and clear; the slave (tracker) returns lock status.
interface fsm_state_tracker_if #(
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             err_clr;
    logic             locked;
    logic [1:0]       state_est;
    logic             sync_pulse;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid,
        output in_bit,
        output err_clr,
        input  locked,
        input  state_est,
        input  sync_pulse,
        input  err_pulse,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  err_clr,
        output locked,
        output state_est,
        output sync_pulse,
        output err_pulse,
        output err_count
    );
endinterface

// File: rtl/fsm_state_tracker.sv
// Locks onto the serial 0,1,0 LSB pattern of a 3-state cyclic FSM, rebuilds its
// 2-bit state, and flags/counts sequence errors once locked.
module fsm_state_tracker #(
    parameter int LOCK_PERIODS = 2,
    parameter int LOSS_THRESH  = 3,
    parameter int ERR_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    fsm_state_tracker_if.slave bus
);
    localparam int GOOD_W = $clog2(LOCK_PERIODS + 1);
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);
    localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_PERIODS);
    localparam logic [MISS_W-1:0] LOSS_TGT = MISS_W'(LOSS_THRESH);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_phase;
    logic [GOOD_W-1:0] r_good_cnt;
    logic [MISS_W-1:0] r_miss_cnt;
    logic [ERR_W-1:0]  r_err_count;
    logic              r_sync_pulse;
    logic              r_err_pulse;

    state_t            w_state_n;
    logic [1:0]        w_phase_n;
    logic [GOOD_W-1:0] w_good_n;
    logic [MISS_W-1:0] w_miss_n;
    logic [ERR_W-1:0]  w_err_count_n;
    logic [ERR_W-1:0]  w_err_base;
    logic              w_sync_n;
    logic              w_err_n;
    logic              w_count_err;
    logic [1:0]        w_nxt;
    logic              w_exp_bit;
    logic              w_match;
    logic [GOOD_W-1:0] w_good_inc;
    logic [MISS_W-1:0] w_miss_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_HUNT;
            r_phase      <= '0;
            r_good_cnt   <= '0;
            r_miss_cnt   <= '0;
            r_err_count  <= '0;
            r_sync_pulse <= 1'b0;
            r_err_pulse  <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_phase      <= w_phase_n;
            r_good_cnt   <= w_good_n;
            r_miss_cnt   <= w_miss_n;
            r_err_count  <= w_err_count_n;
            r_sync_pulse <= w_sync_n;
            r_err_pulse  <= w_err_n;
        end
    end

    always_comb begin
        w_nxt      = (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
        w_exp_bit  = (w_nxt == 2'd1);
        w_match    = (bus.in_bit == w_exp_bit);
        w_good_inc = r_good_cnt + GOOD_W'(1);
        w_miss_inc = r_miss_cnt + MISS_W'(1);

        w_state_n   = r_state;
        w_phase_n   = r_phase;
        w_good_n    = r_good_cnt;
        w_miss_n    = r_miss_cnt;
        w_sync_n    = 1'b0;
        w_err_n     = 1'b0;
        w_count_err = 1'b0;

        if (bus.in_valid) begin
            unique case (r_state)
                ST_HUNT: begin
                    if (bus.in_bit) begin
                        w_phase_n = 2'd1;
                        w_good_n  = '0;
                        w_state_n = ST_VERIFY;
                    end else begin
                        w_phase_n = 2'd0;
                    end
                end
                ST_VERIFY: begin
                    if (w_match) begin
                        w_phase_n = w_nxt;
                        if (w_nxt == 2'd1) begin
                            w_good_n = w_good_inc;
                            if (w_good_inc == LOCK_TGT) begin
                                w_state_n = ST_LOCKED;
                                w_miss_n  = '0;
                            end
                        end
                    end else if (bus.in_bit) begin
                        // A '1' only ever marks S1, so an unexpected one realigns in place
                        w_phase_n = 2'd1;
                        w_good_n  = '0;
                    end else begin
                        w_state_n = ST_HUNT;
                        w_phase_n = 2'd0;
                        w_good_n  = '0;
                    end
                end
                ST_LOCKED: begin
                    w_phase_n = w_nxt;
                    if (w_match) begin
                        w_miss_n = '0;
                        w_sync_n = (w_nxt == 2'd1);
                    end else begin
                        w_err_n     = 1'b1;
                        w_count_err = 1'b1;
                        if (w_miss_inc == LOSS_TGT) begin
                            w_state_n = ST_HUNT;
                            w_phase_n = 2'd0;
                            w_miss_n  = '0;
                        end else begin
                            w_miss_n = w_miss_inc;
                        end
                    end
                end
                default: begin
                    w_state_n = ST_HUNT;
                    w_phase_n = 2'd0;
                    w_good_n  = '0;
                    w_miss_n  = '0;
                end
            endcase
        end

        // Clear takes effect first so a coincident counted mismatch lands as 1
        w_err_base    = bus.err_clr ? '0 : r_err_count;
        w_err_count_n = w_err_base;
        if (w_count_err && (w_err_base != '1)) begin
            w_err_count_n = w_err_base + ERR_W'(1);
        end
    end

    assign bus.locked     = (r_state == ST_LOCKED);
    assign bus.state_est  = (r_state == ST_HUNT) ? 2'd0 : r_phase;
    assign bus.sync_pulse = r_sync_pulse;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_count  = r_err_count;

    assert property (@(posedge clk) disable iff (reset) !(r_sync_pulse && r_err_pulse));
    assert property (@(posedge clk) disable iff (reset) r_phase != 2'd3);
endmodule
